id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline stage register for the 5-stage MIPS core.
- Captures the decoded control bundle from the main decoder, plus register-file read data, the sign-extended immediate, register addresses and funct, and presents them to EX one cycle later.
- Contains load-use hazard detection: stalls PC and IF/ID and inserts a bubble into EX.
- Accepts flush from the branch/jump resolution logic and a global hold from the memory system.

Parameters:
- DW, 32, datapath width (register data, immediate)
- AW, 5, register address width
- CW, 16, width of saturating bubble counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- hold_i  in  1  global freeze; all state retained
- flush_i  in  1  branch/jump taken; kill ID instruction
- valid_i  in  1  ID slot holds a real instruction
- RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i, RegDst_i, ALUSrc_i, Jump_i  in  1 each  decoder outputs
- ALUOp_i  in  2  decoder ALU op class
- RS_data_i, RT_data_i  in  DW  register-file read data
- imm_i  in  DW  sign-extended immediate
- RS_addr_i, RT_addr_i, RD_addr_i  in  AW  instruction fields
- funct_i  in  6  instruction funct field
- RegWrite_o ... Jump_o, ALUOp_o  out  same widths  registered control to EX
- RS_data_o, RT_data_o, imm_o, RS_addr_o, RT_addr_o, RD_addr_o, funct_o  out  registered datapath fields
- valid_o  out  1  EX slot holds a real instruction
- stall_o  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt_o  out  CW  saturating count of hazard bubbles inserted

Behaviour:
- Reset (rst_i=0, async): all registered outputs 0, including valid_o and bubble_cnt_o. stall_o=0 while in reset.
- uses_rt = (ALUSrc_i==0) | MemWrite_i.
- Hazard: stall_o = valid_i & valid_o & MemRead_o & (RT_addr_o!=0) & ((RT_addr_o==RS_addr_i) | (uses_rt & RT_addr_o==RT_addr_i)). Purely combinational, same cycle, no register in the path.
- Each rising edge, priority order:
  1. hold_i=1: every register retains its value; bubble_cnt_o unchanged; stall_o still driven from current values.
  2. flush_i=1: the eight 1-bit controls, ALUOp_o and valid_o load 0; datapath fields load from inputs; no count.
  3. stall_o=1: bubble. Controls and valid_o load 0; datapath fields load from inputs; bubble_cnt_o += 1, saturating at 2^CW-1.
  4. Otherwise: all fields load inputs; valid_o <= valid_i.
- valid_i=0 in the normal case: controls still load, but valid_o=0. EX must gate all side effects with valid_o.
- Latency: exactly 1 cycle from ID inputs to outputs.
- A stalled instruction stays in ID (upstream holds it). The next cycle, the bubble has MemRead_o=0, so stall_o drops and the instruction advances. A load-use hazard therefore costs exactly 1 bubble.
- Simultaneous flush_i and stall_o: flush wins, counter does not increment.
- Reset asserted mid-operation clears state immediately regardless of hold_i.
- Counter saturation: at all-ones, further bubbles leave it unchanged; no wrap.

Test Plan:
- Reset and pass-through: rst_i low then high; drive addi (RegWrite=1, ALUSrc=1, ALUOp=00, imm=0x0000_0005, RT_addr=8, valid=1) -> all outputs 0 during reset; matching values one cycle after release; valid_o=1; stall_o=0.
- Load-use on rs: lw $8 in EX (MemRead_o=1, RT_addr_o=8), ID add with RS_addr_i=8 -> stall_o=1 that cycle; next cycle all controls and valid_o=0, bubble_cnt_o=1; the following edge the add is captured with RegWrite_o=1.
- rt filter: EX lw $9; ID addi with RT_addr_i=9, ALUSrc=1 -> stall_o=0. ID sw with RT_addr_i=9 -> stall_o=1. EX lw $0 with RS_addr_i=0 -> stall_o=0.
- Flush vs stall: hazard present with flush_i=1 -> bubble captured, bubble_cnt_o unchanged.
- Hold: hold_i=1 for 3 cycles with changing inputs -> outputs frozen. Pull rst_i low during the hold -> outputs clear asynchronously, before the next clock edge.
- Saturation: CW=2, force 5 consecutive load-use hazards -> bubble_cnt_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core: captures the decoded bundle,
// detects load-use hazards against the load sitting in EX, and counts inserted bubbles.
module id_ex_pipe_reg #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hold_i,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic          RegWrite_i,
    input  logic          MemtoReg_i,
    input  logic          Branch_i,
    input  logic          MemRead_i,
    input  logic          MemWrite_i,
    input  logic          RegDst_i,
    input  logic          ALUSrc_i,
    input  logic          Jump_i,
    input  logic [1:0]    ALUOp_i,
    input  logic [DW-1:0] RS_data_i,
    input  logic [DW-1:0] RT_data_i,
    input  logic [DW-1:0] imm_i,
    input  logic [AW-1:0] RS_addr_i,
    input  logic [AW-1:0] RT_addr_i,
    input  logic [AW-1:0] RD_addr_i,
    input  logic [5:0]    funct_i,
    output logic          RegWrite_o,
    output logic          MemtoReg_o,
    output logic          Branch_o,
    output logic          MemRead_o,
    output logic          MemWrite_o,
    output logic          RegDst_o,
    output logic          ALUSrc_o,
    output logic          Jump_o,
    output logic [1:0]    ALUOp_o,
    output logic [DW-1:0] RS_data_o,
    output logic [DW-1:0] RT_data_o,
    output logic [DW-1:0] imm_o,
    output logic [AW-1:0] RS_addr_o,
    output logic [AW-1:0] RT_addr_o,
    output logic [AW-1:0] RD_addr_o,
    output logic [5:0]    funct_o,
    output logic          valid_o,
    output logic          stall_o,
    output logic [CW-1:0] bubble_cnt_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic uses_rt;
    logic rs_match;
    logic rt_match;
    logic kill;

    // valid_i/valid_o qualify the ID and EX slots; there is no ready, the only
    // back-pressure is stall_o (upstream re-presents the same ID instruction) and hold_i.
    assign uses_rt  = ~ALUSrc_i | MemWrite_i;
    assign rs_match = (RT_addr_o == RS_addr_i);
    assign rt_match = (RT_addr_o == RT_addr_i);
    assign stall_o  = valid_i & valid_o & MemRead_o & (RT_addr_o != '0)
                    & (rs_match | (uses_rt & rt_match));
    assign kill     = flush_i | stall_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegWrite_o   <= 1'b0;
            MemtoReg_o   <= 1'b0;
            Branch_o     <= 1'b0;
            MemRead_o    <= 1'b0;
            MemWrite_o   <= 1'b0;
            RegDst_o     <= 1'b0;
            ALUSrc_o     <= 1'b0;
            Jump_o       <= 1'b0;
            ALUOp_o      <= 2'b00;
            RS_data_o    <= '0;
            RT_data_o    <= '0;
            imm_o        <= '0;
            RS_addr_o    <= '0;
            RT_addr_o    <= '0;
            RD_addr_o    <= '0;
            funct_o      <= '0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= '0;
        end else if (!hold_i) begin
            RS_data_o <= RS_data_i;
            RT_data_o <= RT_data_i;
            imm_o     <= imm_i;
            RS_addr_o <= RS_addr_i;
            RT_addr_o <= RT_addr_i;
            RD_addr_o <= RD_addr_i;
            funct_o   <= funct_i;
            // Flush and bubble both turn EX into a no-op; datapath fields are don't-care then.
            if (kill) begin
                RegWrite_o <= 1'b0;
                MemtoReg_o <= 1'b0;
                Branch_o   <= 1'b0;
                MemRead_o  <= 1'b0;
                MemWrite_o <= 1'b0;
                RegDst_o   <= 1'b0;
                ALUSrc_o   <= 1'b0;
                Jump_o     <= 1'b0;
                ALUOp_o    <= 2'b00;
                valid_o    <= 1'b0;
            end else begin
                RegWrite_o <= RegWrite_i;
                MemtoReg_o <= MemtoReg_i;
                Branch_o   <= Branch_i;
                MemRead_o  <= MemRead_i;
                MemWrite_o <= MemWrite_i;
                RegDst_o   <= RegDst_i;
                ALUSrc_o   <= ALUSrc_i;
                Jump_o     <= Jump_i;
                ALUOp_o    <= ALUOp_i;
                valid_o    <= valid_i;
            end
            // Only hazard bubbles count; a flush in the same cycle takes precedence.
            if (stall_o && !flush_i && bubble_cnt_o != CNT_MAX) begin
                bubble_cnt_o <= bubble_cnt_o + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table, hand-written hold/reset/saturation
// sequences, and random traffic checked against a stage-level reference model.
module tb_id_ex_pipe_reg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int CKW  = 160;
    localparam int NV   = 13;
    localparam int NRND = 400;

    typedef struct packed {
        logic          valid;
        logic          reg_write;
        logic          mem_to_reg;
        logic          branch;
        logic          mem_read;
        logic          mem_write;
        logic          reg_dst;
        logic          alu_src;
        logic          jump;
        logic [1:0]    alu_op;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [AW-1:0] rs_addr;
        logic [AW-1:0] rt_addr;
        logic [AW-1:0] rd_addr;
        logic [5:0]    funct;
    } stage_t;

    typedef struct {
        stage_t        id;
        logic          hold;
        logic          flush;
        logic          stall;
        logic          valid;
        logic          rw;
        logic          mr;
        logic [AW-1:0] rt;
        logic [CW-1:0] cnt;
        logic          full;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic   rst_i = 1'b0;
    logic   hold_i = 1'b0;
    logic   flush_i = 1'b0;
    stage_t id_in = '0;

    logic          RegWrite_o, MemtoReg_o, Branch_o, MemRead_o;
    logic          MemWrite_o, RegDst_o, ALUSrc_o, Jump_o;
    logic [1:0]    ALUOp_o;
    logic [DW-1:0] RS_data_o, RT_data_o, imm_o;
    logic [AW-1:0] RS_addr_o, RT_addr_o, RD_addr_o;
    logic [5:0]    funct_o;
    logic          valid_o, stall_o;
    logic [CW-1:0] bubble_cnt_o;
    stage_t        ex_out;

    assign ex_out = {valid_o, RegWrite_o, MemtoReg_o, Branch_o, MemRead_o, MemWrite_o,
                     RegDst_o, ALUSrc_o, Jump_o, ALUOp_o, RS_data_o, RT_data_o, imm_o,
                     RS_addr_o, RT_addr_o, RD_addr_o, funct_o};

    id_ex_pipe_reg #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .valid_i(id_in.valid),
        .RegWrite_i(id_in.reg_write), .MemtoReg_i(id_in.mem_to_reg), .Branch_i(id_in.branch),
        .MemRead_i(id_in.mem_read), .MemWrite_i(id_in.mem_write), .RegDst_i(id_in.reg_dst),
        .ALUSrc_i(id_in.alu_src), .Jump_i(id_in.jump), .ALUOp_i(id_in.alu_op),
        .RS_data_i(id_in.rs_data), .RT_data_i(id_in.rt_data), .imm_i(id_in.imm),
        .RS_addr_i(id_in.rs_addr), .RT_addr_i(id_in.rt_addr), .RD_addr_i(id_in.rd_addr),
        .funct_i(id_in.funct),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .Branch_o(Branch_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .RegDst_o(RegDst_o),
        .ALUSrc_o(ALUSrc_o), .Jump_o(Jump_o), .ALUOp_o(ALUOp_o),
        .RS_data_o(RS_data_o), .RT_data_o(RT_data_o), .imm_o(imm_o),
        .RS_addr_o(RS_addr_o), .RT_addr_o(RT_addr_o), .RD_addr_o(RD_addr_o),
        .funct_o(funct_o), .valid_o(valid_o), .stall_o(stall_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    // ---------------- scoreboard / reference model ----------------
    int             total = 0;
    int             bad = 0;
    stage_t         m_ex = '0;
    int             m_cnt = 0;
    logic [CKW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [CKW-1:0] got, input logic [CKW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // An ID instruction must wait if it reads the register a valid load in EX is about to write.
    function automatic logic load_use(input stage_t ex, input stage_t id);
        logic reads_rt;
        reads_rt = !id.alu_src || id.mem_write;
        return id.valid && ex.valid && ex.mem_read && ex.rt_addr != 0 &&
               (ex.rt_addr == id.rs_addr || (reads_rt && ex.rt_addr == id.rt_addr));
    endfunction

    function automatic stage_t as_nop(input stage_t s);
        stage_t r;
        r = s;
        r.valid = 1'b0;
        {r.reg_write, r.mem_to_reg, r.branch, r.mem_read,
         r.mem_write, r.reg_dst, r.alu_src, r.jump} = 8'h00;
        r.alu_op = 2'b00;
        return r;
    endfunction

    function automatic stage_t mk(input logic [7:0] ctrl, input logic [1:0] op,
                                  input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                  input logic [AW-1:0] rd, input logic [DW-1:0] imm,
                                  input logic [5:0] funct);
        stage_t s;
        s = '0;
        s.valid = 1'b1;
        {s.reg_write, s.mem_to_reg, s.branch, s.mem_read,
         s.mem_write, s.reg_dst, s.alu_src, s.jump} = ctrl;
        s.alu_op  = op;
        s.rs_data = $urandom;
        s.rt_data = $urandom;
        s.imm     = imm;
        s.rs_addr = rs;
        s.rt_addr = rt;
        s.rd_addr = rd;
        s.funct   = funct;
        return s;
    endfunction

    function automatic stage_t i_addi(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [DW-1:0] imm);
        return mk(8'h82, 2'b00, rs, rt, 5'd0, imm, 6'h00);
    endfunction
    function automatic stage_t i_lw(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        return mk(8'hD2, 2'b00, rs, rt, 5'd0, 32'h0000_0010, 6'h00);
    endfunction
    function automatic stage_t i_sw(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        return mk(8'h0A, 2'b00, rs, rt, 5'd0, 32'h0000_0004, 6'h00);
    endfunction
    function automatic stage_t i_add(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        return mk(8'h84, 2'b10, rs, rt, rd, 32'h0000_0000, 6'h20);
    endfunction

    function automatic stage_t rnd_stage();
        stage_t s;
        s = '0;
        s.valid     = ($urandom_range(0, 3) != 0);
        {s.reg_write, s.mem_to_reg, s.branch, s.mem_write, s.reg_dst, s.alu_src, s.jump} = 7'($urandom);
        s.mem_read  = ($urandom_range(0, 1) == 0);
        s.alu_op    = 2'($urandom);
        s.rs_data   = $urandom;
        s.rt_data   = $urandom;
        s.imm       = $urandom;
        s.rs_addr   = AW'($urandom_range(0, 3));
        s.rt_addr   = AW'($urandom_range(0, 3));
        s.rd_addr   = AW'($urandom);
        s.funct     = 6'($urandom);
        return s;
    endfunction

    // ---------------- driver ----------------
    // Entered just after a rising edge; leaves just after the next one.
    task automatic cycle(input stage_t id, input logic hold, input logic flush);
        logic           hz;
        logic [CKW-1:0] exp;
        id_in   = id;
        hold_i  = hold;
        flush_i = flush;
        @(negedge clk_i);
        hz = load_use(m_ex, id);
        chk("stall", CKW'(stall_o), CKW'(hz));
        if (!hold) begin
            if (flush) begin
                m_ex = as_nop(id);
            end else if (hz) begin
                m_ex = as_nop(id);
                if (m_cnt < CMAX) m_cnt++;
            end else begin
                m_ex = id;
            end
        end
        exp_q.push_back(CKW'({m_ex, CW'(m_cnt)}));
        @(posedge clk_i);
        #1;
        exp = exp_q.pop_front();
        chk("ex_regs", CKW'({ex_out, bubble_cnt_o}), exp);
    endtask

    task automatic do_reset(input stage_t id);
        rst_i   = 1'b0;
        hold_i  = 1'b0;
        flush_i = 1'b0;
        id_in   = id;
        @(posedge clk_i);
        #1;
        chk("rst_regs", CKW'({ex_out, bubble_cnt_o}), '0);
        chk("rst_stall", CKW'(stall_o), '0);
        rst_i = 1'b1;
        m_ex  = '0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    vec_t          vt[NV];
    logic [CW-1:0] exp_sat[5];
    stage_t        snap;

    initial begin
        vt[0]  = '{i_addi(5'd0, 5'd8, 32'h5),    0, 0, 0, 1, 1, 0, 5'd8, 2'd0, 1};
        vt[1]  = '{i_lw(5'd0, 5'd8),             0, 0, 0, 1, 1, 1, 5'd8, 2'd0, 0};
        vt[2]  = '{i_add(5'd8, 5'd3, 5'd10),     0, 0, 1, 0, 0, 0, 5'd3, 2'd1, 0};
        vt[3]  = '{i_add(5'd8, 5'd3, 5'd10),     0, 0, 0, 1, 1, 0, 5'd3, 2'd1, 0};
        vt[4]  = '{i_lw(5'd0, 5'd9),             0, 0, 0, 1, 1, 1, 5'd9, 2'd1, 0};
        vt[5]  = '{i_addi(5'd1, 5'd9, 32'h7),    1, 0, 0, 1, 1, 1, 5'd9, 2'd1, 0};
        vt[6]  = '{i_sw(5'd2, 5'd9),             0, 0, 1, 0, 0, 0, 5'd9, 2'd2, 0};
        vt[7]  = '{i_sw(5'd2, 5'd9),             0, 0, 0, 1, 0, 0, 5'd9, 2'd2, 0};
        vt[8]  = '{i_lw(5'd0, 5'd0),             0, 0, 0, 1, 1, 1, 5'd0, 2'd2, 0};
        vt[9]  = '{i_add(5'd0, 5'd0, 5'd4),      0, 0, 0, 1, 1, 0, 5'd0, 2'd2, 0};
        vt[10] = '{i_lw(5'd0, 5'd5),             0, 0, 0, 1, 1, 1, 5'd5, 2'd2, 0};
        vt[11] = '{i_add(5'd5, 5'd6, 5'd7),      0, 1, 1, 0, 0, 0, 5'd6, 2'd2, 0};
        vt[12] = '{i_add(5'd5, 5'd6, 5'd7),      0, 0, 0, 0, 1, 0, 5'd6, 2'd2, 0};
        vt[12].id.valid = 1'b0;
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Directed table, starting from reset with an addi already on the inputs.
        do_reset(vt[0].id);
        for (int i = 0; i < NV; i++) begin
            id_in   = vt[i].id;
            hold_i  = vt[i].hold;
            flush_i = vt[i].flush;
            @(negedge clk_i);
            chk($sformatf("v%0d_stall", i), CKW'(stall_o), CKW'(vt[i].stall));
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_valid", i), CKW'(valid_o), CKW'(vt[i].valid));
            chk($sformatf("v%0d_regwrite", i), CKW'(RegWrite_o), CKW'(vt[i].rw));
            chk($sformatf("v%0d_memread", i), CKW'(MemRead_o), CKW'(vt[i].mr));
            chk($sformatf("v%0d_rt_addr", i), CKW'(RT_addr_o), CKW'(vt[i].rt));
            chk($sformatf("v%0d_bubbles", i), CKW'(bubble_cnt_o), CKW'(vt[i].cnt));
            if (vt[i].full) chk($sformatf("v%0d_pass", i), CKW'(ex_out), CKW'(vt[i].id));
        end

        // Hold for three cycles with changing inputs, then async reset inside the hold.
        do_reset('0);
        cycle(i_lw(5'd0, 5'd4), 0, 0);
        cycle(i_add(5'd4, 5'd2, 5'd3), 0, 0);
        cycle(i_add(5'd4, 5'd2, 5'd3), 0, 0);
        snap = m_ex;
        for (int i = 0; i < 3; i++) begin
            cycle(rnd_stage(), 1, 0);
            chk("hold_frozen", CKW'({ex_out, bubble_cnt_o}), CKW'({snap, CW'(1)}));
        end
        hold_i = 1'b1;
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_rst_regs", CKW'({ex_out, bubble_cnt_o}), '0);
        chk("async_rst_stall", CKW'(stall_o), '0);
        @(posedge clk_i);
        #1;
        rst_i  = 1'b1;
        hold_i = 1'b0;
        m_ex   = '0;
        m_cnt  = 0;

        // Five back-to-back load-use hazards against a 2-bit counter.
        do_reset('0);
        for (int i = 0; i < 5; i++) begin
            cycle(i_lw(5'd0, 5'd7), 0, 0);
            cycle(i_add(5'd7, 5'd1, 5'd2), 0, 0);
            chk($sformatf("sat_%0d", i), CKW'(bubble_cnt_o), CKW'(exp_sat[i]));
        end

        // Random traffic with dense register aliasing.
        do_reset('0);
        for (int i = 0; i < NRND; i++) begin
            cycle(rnd_stage(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
